// File: rtl/spike_tx_pkg.sv
// Shared types and constants for the spike frame transmitter.
// The repetition counter width applies only when FRAME_REPEAT_EN is defined.
package spike_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam int REP_W = 4;

    function automatic int calc_beats(input int inputs, input int byte_w);
        return inputs / byte_w;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_frame_tx_if.sv
// Frame-in / byte-out bundle of the spike frame transmitter.
// The repeat_cnt signal exists only when FRAME_REPEAT_EN is defined.
interface spike_frame_tx_if #(
    parameter int INPUTS = 32,
    parameter int BYTE_W = 8
);
    import spike_tx_pkg::*;

    logic [INPUTS-1:0] frame_in;
    logic              frame_valid;
    logic              frame_ready;
`ifdef FRAME_REPEAT_EN
    logic [REP_W-1:0]  repeat_cnt;
`endif
    logic [BYTE_W-1:0] byte_out;
    logic              byte_valid;
    logic              frame_start;
    logic              frame_done;
    logic              busy;

    // Transmitter side.
    modport slave (
`ifdef FRAME_REPEAT_EN
        input  repeat_cnt,
`endif
        input  frame_in, frame_valid,
        output frame_ready, byte_out, byte_valid, frame_start, frame_done, busy
    );

    // Spike source / consumer side.
    modport master (
`ifdef FRAME_REPEAT_EN
        output repeat_cnt,
`endif
        output frame_in, frame_valid,
        input  frame_ready, byte_out, byte_valid, frame_start, frame_done, busy
    );

endinterface

// File: rtl/spike_beat_counter.sv
// Beat and repetition counters for the spike frame transmitter.
// The repetition counter and its limit exist only when FRAME_REPEAT_EN is defined.
module spike_beat_counter
    import spike_tx_pkg::*;
#(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
`ifdef FRAME_REPEAT_EN
    input  logic [REP_W-1:0]  rep_limit,
`endif
    output logic [BEAT_W-1:0] beat_nxt,
    output logic              nxt_final,
    output logic              last_beat,
    output logic              last_rep
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0] beat_q, beat_d;

    assign last_beat = (beat_q == LAST_BEAT);
    assign beat_nxt  = beat_d;

`ifdef FRAME_REPEAT_EN
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] lim_q, lim_d;

    assign last_rep  = (rep_q == lim_q);
    assign nxt_final = (beat_d == LAST_BEAT) && (rep_d == lim_d);

    always_comb begin
        beat_d = beat_q;
        rep_d  = rep_q;
        lim_d  = lim_q;
        if (load) begin
            beat_d = '0;
            rep_d  = '0;
            lim_d  = rep_limit;
        end else if (advance) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
            rep_d  = last_beat ? rep_q + 1'b1 : rep_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= '0;
            rep_q  <= '0;
            lim_q  <= '0;
        end else begin
            beat_q <= beat_d;
            rep_q  <= rep_d;
            lim_q  <= lim_d;
        end
    end
`else
    // Without repetition every pass through the frame is the final one.
    assign last_rep  = 1'b1;
    assign nxt_final = (beat_d == LAST_BEAT);

    always_comb begin
        beat_d = beat_q;
        if (load) begin
            beat_d = '0;
        end else if (advance) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end
`endif

endmodule

// File: rtl/spike_frame_tx.sv
// Spike frame transmitter: latches a frame and streams it out one byte per cycle,
// lowest byte first. Optional frame repetition is enabled by FRAME_REPEAT_EN.
module spike_frame_tx
    import spike_tx_pkg::*;
#(
    parameter int INPUTS = 32,
    parameter int BYTE_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    spike_frame_tx_if.slave        bus
);

    localparam int BEATS  = calc_beats(INPUTS, BYTE_W);
    localparam int BEAT_W = idx_width(BEATS);

    state_e            state_q, state_d;
    logic [INPUTS-1:0] frame_q, frame_d;
    logic [BYTE_W-1:0] byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;

    logic              load, advance, accept, frame_ready;
    logic              last_beat, last_rep, nxt_final;
    logic [BEAT_W-1:0] beat_nxt;
    int                beat_sel;

    spike_beat_counter #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .advance   (advance),
`ifdef FRAME_REPEAT_EN
        .rep_limit (bus.repeat_cnt),
`endif
        .beat_nxt  (beat_nxt),
        .nxt_final (nxt_final),
        .last_beat (last_beat),
        .last_rep  (last_rep)
    );

    // Ready in IDLE and on the final beat, so a waiting frame follows with no bubble.
    assign frame_ready = !reset && ((state_q == IDLE) || (last_beat && last_rep));
    assign accept      = bus.frame_valid && frame_ready;

    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        load          = 1'b0;
        advance       = 1'b0;
        frame_start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load          = 1'b1;
                    frame_d       = bus.frame_in;
                    frame_start_d = 1'b1;
                    state_d       = SEND;
                end
            end
            SEND: begin
                if (last_beat && last_rep) begin
                    if (accept) begin
                        load          = 1'b1;
                        frame_d       = bus.frame_in;
                        frame_start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output registers hold the beat that the counters point at after this edge.
        byte_valid_d = load || advance;
        frame_done_d = byte_valid_d && nxt_final;
        beat_sel     = int'(beat_nxt) * BYTE_W;
        byte_out_d   = byte_valid_d ? frame_d[beat_sel +: BYTE_W] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            byte_out_q    <= '0;
            byte_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_out_q    <= byte_out_d;
            byte_valid_q  <= byte_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
        frame_q <= frame_d;
    end

    assign bus.frame_ready = frame_ready;
    assign bus.byte_out    = byte_out_q;
    assign bus.byte_valid  = byte_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = (state_q == SEND);

endmodule

// File: tb/tb_spike_frame_tx.sv
// Self-checking bench for spike_frame_tx: directed steps plus random traffic against
// a beat-queue reference model. Repetition steps run only with FRAME_REPEAT_EN.
module tb_spike_frame_tx;

    localparam int INPUTS = 32;
    localparam int BYTE_W = 8;
    localparam int BEATS  = INPUTS / BYTE_W;

    logic clk;
    logic reset;

    spike_frame_tx_if #(.INPUTS(INPUTS), .BYTE_W(BYTE_W)) bus ();

    spike_frame_tx #(.INPUTS(INPUTS), .BYTE_W(BYTE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       s;
        logic       d;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every accepted frame becomes (rep+1)*BEATS expected beats.
    task automatic push_frame(input logic [31:0] f, input int rep);
        for (int r = 0; r <= rep; r++) begin
            for (int k = 0; k < BEATS; k++) begin
                beat_t e;
                e.b = f[k*BYTE_W +: BYTE_W];
                e.s = (r == 0) && (k == 0);
                e.d = (r == rep) && (k == BEATS - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic check_model();
        logic [7:0] eb;
        logic       ev, es, ed;
        if (q.size() > 0) begin
            eb = q[0].b; ev = 1'b1; es = q[0].s; ed = q[0].d;
        end else begin
            eb = 8'h00; ev = 1'b0; es = 1'b0; ed = 1'b0;
        end
        chk("byte_out",    bus.byte_out,    eb);
        chk("byte_valid",  bus.byte_valid,  ev);
        chk("frame_start", bus.frame_start, es);
        chk("frame_done",  bus.frame_done,  ed);
        chk("busy",        bus.busy,        (q.size() > 0));
        chk("frame_ready", bus.frame_ready, (!reset && q.size() <= 1));
    endtask

    // One clock: the model consumes the inputs held across the edge, then outputs are checked.
    task automatic cycle();
        bit          acc;
        int          rep;
        logic [31:0] f;
        acc = bus.frame_valid && !reset && (q.size() <= 1);
        f   = bus.frame_in;
`ifdef FRAME_REPEAT_EN
        rep = int'(bus.repeat_cnt);
`else
        rep = 0;
`endif
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            if (q.size() > 0) q.delete(0);
            if (acc) push_frame(f, rep);
        end
        #1;
        check_model();
    endtask

    logic [7:0] exp_t1  [4] = '{8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] exp_b2b [8] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    logic       rdy_b2b [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] exp_mid [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0] exp_rep [4] = '{8'h04, 8'h03, 8'h02, 8'h01};

    initial begin
        int starts;
        int dones;

        reset           = 1'b1;
        bus.frame_valid = 1'b0;
        bus.frame_in    = '0;
`ifdef FRAME_REPEAT_EN
        bus.repeat_cnt  = '0;
`endif

        // Reset, with a frame offered that must be ignored.
        cycle();
        bus.frame_valid = 1'b1;
        bus.frame_in    = 32'h1234_5678;
        cycle();
        chk("rst_ready", bus.frame_ready, 1'b0);
        bus.frame_valid = 1'b0;
        reset = 1'b0;
        cycle();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ready_after", bus.frame_ready, 1'b1);

        // Single frame.
        bus.frame_in    = 32'h8040_2010;
        bus.frame_valid = 1'b1;
        cycle();
        bus.frame_valid = 1'b0;
        chk("t1_byte0", bus.byte_out, exp_t1[0]);
        chk("t1_start", bus.frame_start, 1'b1);
        for (int i = 1; i < 4; i++) begin
            cycle();
            chk("t1_byte", bus.byte_out, exp_t1[i]);
            chk("t1_done", bus.frame_done, (i == 3));
        end
        cycle();
        chk("t1_after_valid", bus.byte_valid, 1'b0);
        chk("t1_after_byte", bus.byte_out, 8'h00);

        // Back-to-back frames with frame_valid held high.
        bus.frame_in    = 32'h0000_00FF;
        bus.frame_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_ready", bus.frame_ready, rdy_b2b[i]);
            cycle();
            chk("b2b_byte", bus.byte_out, exp_b2b[i]);
            chk("b2b_valid", bus.byte_valid, 1'b1);
            if (i == 0) bus.frame_in = 32'hFF00_0000;
            if (i == 4) bus.frame_valid = 1'b0;
        end
        cycle();
        cycle();

        // A different frame offered mid-SEND waits for the final beat.
        bus.frame_in    = 32'h1122_3344;
        bus.frame_valid = 1'b1;
        cycle();
        bus.frame_in = 32'hAAAA_AAAA;
        chk("mid_byte", bus.byte_out, exp_mid[0]);
        for (int i = 1; i < 4; i++) begin
            cycle();
            chk("mid_byte", bus.byte_out, exp_mid[i]);
        end
        chk("mid_ready_last", bus.frame_ready, 1'b1);
        cycle();
        bus.frame_valid = 1'b0;
        chk("mid_next_byte", bus.byte_out, 8'hAA);
        chk("mid_next_start", bus.frame_start, 1'b1);
        for (int i = 0; i < 4; i++) cycle();

        // Reset in the middle of a frame drops it without frame_done.
        bus.frame_in    = 32'hDEAD_BEEF;
        bus.frame_valid = 1'b1;
        cycle();
        bus.frame_valid = 1'b0;
        cycle();
        cycle();
        chk("rst_mid_beat2", bus.byte_out, 8'hAD);
        reset = 1'b1;
        cycle();
        chk("rst_mid_valid", bus.byte_valid, 1'b0);
        chk("rst_mid_done", bus.frame_done, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_mid_ready", bus.frame_ready, 1'b1);
        bus.frame_in    = 32'h0BAD_F00D;
        bus.frame_valid = 1'b1;
        cycle();
        bus.frame_valid = 1'b0;
        chk("rst_mid_new", bus.byte_out, 8'h0D);
        for (int i = 0; i < 4; i++) cycle();

`ifdef FRAME_REPEAT_EN
        // Three repetitions of one frame.
        starts = 0;
        dones  = 0;
        bus.frame_in    = 32'h0102_0304;
        bus.repeat_cnt  = 4'd2;
        bus.frame_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (i == 0) begin
                bus.frame_valid = 1'b0;
                bus.repeat_cnt  = 4'd0;
            end
            chk("rep_byte", bus.byte_out, exp_rep[i % 4]);
            if (bus.frame_start === 1'b1) starts++;
            if (bus.frame_done === 1'b1) dones++;
            if (i == 11) chk("rep_done_last", bus.frame_done, 1'b1);
        end
        chk("rep_starts", starts, 1);
        chk("rep_dones", dones, 1);
        cycle();
        chk("rep_idle", bus.busy, 1'b0);
`endif

        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            bus.frame_valid = 1'($urandom_range(0, 1));
            bus.frame_in    = $urandom;
`ifdef FRAME_REPEAT_EN
            bus.repeat_cnt  = 4'($urandom_range(0, 3));
`endif
            reset = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reset           = 1'b0;
        bus.frame_valid = 1'b0;
        for (int i = 0; i < 20; i++) cycle();

        // Long idle.
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("idle_byte", bus.byte_out, 8'h00);
            chk("idle_busy", bus.busy, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
